dp_mem_arb2: RTL and testbench
==============================

Name: dp_mem_arb2

Overview:
- Two-requester arbiter that shares one dp_mem_512x8b instance between requester A (core data path) and requester B (loader/debug path).
- Read port and write port are arbitrated independently, so a read from one requester and a write from the other both proceed in the same cycle.
- Fairness is per-port round-robin.
- Same-cycle read/write to the same address is resolved by a write-to-read bypass, so results never depend on RAM collision behaviour.

Parameters:
- AW, 9, address width; matches 512-entry memory.
- DW, 8, data width.

Ports:
- i_clk  input  1  clock
- i_nrst  input  1  asynchronous active-low reset
- i_a_req  input  1  A request; held until granted
- i_a_we  input  1  A request is write (1) or read (0)
- i_a_addr  input  AW  A address
- i_a_wdata  input  DW  A write data
- o_a_gnt  output  1  A request accepted this cycle
- o_a_rvalid  output  1  A read data valid
- o_a_rdata  output  DW  A read data
- i_b_req, i_b_we, i_b_addr, i_b_wdata, o_b_gnt, o_b_rvalid, o_b_rdata: same as A, for requester B
- o_mem_we  output  1  to memory i_we
- o_mem_waddr  output  AW  to memory i_waddr
- o_mem_wdata  output  DW  to memory i_wdata
- o_mem_raddr  output  AW  to memory i_raddr
- i_mem_rdata  input  DW  from memory o_rdata; valid one cycle after raddr is presented

Behaviour:
- Reset (async, i_nrst low): wr_last=B and rd_last=B, so A wins the first contention on each port. rvalid flags, bypass flag and bypass register are cleared. Every output reads 0.
- Grants are combinational, same cycle as req. A requester must hold req/we/addr/wdata stable until gnt is high; a transfer completes on the gnt cycle.
- Write port:
  - Candidates are requesters with req&we.
  - One candidate: it is granted.
  - Two candidates: the one not equal to wr_last is granted, and wr_last updates to the winner.
  - On a granted write: o_mem_we=1, o_mem_waddr/o_mem_wdata driven from the winner.
  - No write granted: o_mem_we=0, o_mem_waddr=0, o_mem_wdata=0.
- Read port:
  - Same rule using req&!we and rd_last.
  - On a granted read: o_mem_raddr = winner addr.
  - No read granted: o_mem_raddr=0.
- Pointer updates: wr_last/rd_last update only when that port actually grants. A single uncontended grant also updates the pointer to the granted requester.
- Read latency: a read granted in cycle N produces rvalid for that requester in cycle N+1 only, as a 1-cycle pulse. Back-to-back reads give rvalid every cycle.
- Read data gating: o_x_rdata = returned data when o_x_rvalid=1, else 0.
- Bypass:
  - Trigger: in cycle N a read and a write are both granted and their addresses are equal.
  - Action: register the write data and set the bypass flag.
  - In cycle N+1 the rdata for that read is the registered write data instead of i_mem_rdata.
  - Otherwise the bypass flag is cleared.
- Write-then-read to the same address in consecutive cycles needs no bypass; the memory supplies the new data.
- Each requester has at most one outstanding read.
- Reset asserted mid-operation: any rvalid due next cycle is dropped (not re-issued). Writes already granted before reset remain in memory.
- Requester-side outputs are driven from the registered state and the grant logic only. There is no combinational path from i_mem_rdata to o_x_gnt.

Test Plan:
- Reset, idle, no req: all outputs 0, o_mem_we=0, o_mem_raddr=0.
- A writes 0x1A5<-0x3C alone: o_a_gnt=1 same cycle, o_mem_we=1, waddr=0x1A5, wdata=0x3C. Next cycle A reads 0x1A5: o_a_rvalid=1 at N+1 with rdata=0x3C.
- A and B both write (0x010<-0x11, 0x020<-0x22) for 4 consecutive cycles after reset: grants go A,B,A,B and each write lands with its own data. Repeat with both reading: grants again alternate A first.
- Same cycle, A reads 0x0FF while B writes 0x0FF<-0x5A: both gnt=1, o_a_rvalid at N+1 with o_a_rdata=0x5A (bypass). Next cycle A reads 0x0FF again: 0x5A from memory.
- A reads 0x000 and B reads 0x1FF back-to-back with contention for 6 cycles: rvalid pulses alternate A/B one cycle after each grant, each with correct data, rdata=0 whenever rvalid=0.
- Read granted in cycle N, i_nrst pulled low mid-cycle N+1: o_a_rvalid=0 immediately, and the next contention after release is won by A on both ports.

Source files
------------

// File: rtl/dp_mem_arb2.sv
// -----------------------------------------------------------------------------
// dp_mem_arb2
//
// Shares one dual-port 512x8 RAM (one write port, one read port with a
// one-cycle read latency) between two requesters:
//   A - core data path
//   B - loader / debug path
//
// The write port and the read port have separate arbiters. A read from one
// requester and a write from the other can therefore both be granted in the
// same cycle. Each port keeps its own round-robin pointer ("last winner"), so
// fairness on one port does not depend on traffic on the other.
//
// If a read and a write are granted to the same address in the same cycle,
// the write data is captured and returned for that read on the next cycle.
// This makes the result independent of the RAM's collision behaviour.
//
// Ports
//   i_clk, i_nrst                   clock, asynchronous active-low reset
//   i_x_req / i_x_we                request, 1 = write / 0 = read (x = a, b);
//                                   held stable until o_x_gnt is high
//   i_x_addr / i_x_wdata            address, write data
//   o_x_gnt                         request accepted this cycle (combinational)
//   o_x_rvalid / o_x_rdata          read data, one cycle after the read grant;
//                                   rdata is 0 when rvalid is low
//   o_mem_we/o_mem_waddr/o_mem_wdata  RAM write port (all 0 when idle)
//   o_mem_raddr                     RAM read address (0 when idle)
//   i_mem_rdata                     RAM read data, valid one cycle after raddr
// -----------------------------------------------------------------------------
module dp_mem_arb2 #(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_nrst,

  input  logic          i_a_req,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_wdata,
  output logic          o_a_gnt,
  output logic          o_a_rvalid,
  output logic [DW-1:0] o_a_rdata,

  input  logic          i_b_req,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [DW-1:0] i_b_wdata,
  output logic          o_b_gnt,
  output logic          o_b_rvalid,
  output logic [DW-1:0] o_b_rdata,

  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_waddr,
  output logic [DW-1:0] o_mem_wdata,
  output logic [AW-1:0] o_mem_raddr,
  input  logic [DW-1:0] i_mem_rdata
);

  // Identifies which requester most recently won a port.
  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  sel_e          r_wr_last;   // last winner on the write port
  sel_e          r_rd_last;   // last winner on the read port
  logic          r_a_rvalid;  // read data for A is due this cycle
  logic          r_b_rvalid;  // read data for B is due this cycle
  logic          r_byp;       // this cycle's read data comes from r_byp_data
  logic [DW-1:0] r_byp_data;  // write data captured on a same-address collision

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic w_a_wr_cand, w_b_wr_cand;
  logic w_a_rd_cand, w_b_rd_cand;
  logic w_wr_gnt_a, w_wr_gnt_b;
  logic w_rd_gnt_a, w_rd_gnt_b;
  logic w_wr_any, w_rd_any;
  logic w_byp_hit;

  assign w_a_wr_cand = i_a_req &  i_a_we;
  assign w_b_wr_cand = i_b_req &  i_b_we;
  assign w_a_rd_cand = i_a_req & ~i_a_we;
  assign w_b_rd_cand = i_b_req & ~i_b_we;

  // A lone candidate always wins. Under contention the requester that did not
  // win last time on this port is granted.
  assign w_wr_gnt_a = w_a_wr_cand & (~w_b_wr_cand | (r_wr_last == SEL_B));
  assign w_wr_gnt_b = w_b_wr_cand & (~w_a_wr_cand | (r_wr_last == SEL_A));
  assign w_rd_gnt_a = w_a_rd_cand & (~w_b_rd_cand | (r_rd_last == SEL_B));
  assign w_rd_gnt_b = w_b_rd_cand & (~w_a_rd_cand | (r_rd_last == SEL_A));

  assign w_wr_any = w_wr_gnt_a | w_wr_gnt_b;
  assign w_rd_any = w_rd_gnt_a | w_rd_gnt_b;

  // A requester is only ever on one port in a given cycle, so its grant is
  // simply the OR of the two port grants.
  assign o_a_gnt = w_wr_gnt_a | w_rd_gnt_a;
  assign o_b_gnt = w_wr_gnt_b | w_rd_gnt_b;

  // ---------------------------------------------------------------------------
  // Memory-side muxing
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default before the if/else
  // chain, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_waddr = '0;
    o_mem_wdata = '0;
    o_mem_raddr = '0;

    if (w_wr_gnt_a) begin
      o_mem_we    = 1'b1;
      o_mem_waddr = i_a_addr;
      o_mem_wdata = i_a_wdata;
    end else if (w_wr_gnt_b) begin
      o_mem_we    = 1'b1;
      o_mem_waddr = i_b_addr;
      o_mem_wdata = i_b_wdata;
    end

    if (w_rd_gnt_a) begin
      o_mem_raddr = i_a_addr;
    end else if (w_rd_gnt_b) begin
      o_mem_raddr = i_b_addr;
    end
  end

  // Same-cycle read and write to one address: the RAM's answer for the read is
  // undefined (or old data), so the write data is forwarded instead.
  assign w_byp_hit = w_wr_any & w_rd_any & (o_mem_waddr == o_mem_raddr);

  // ---------------------------------------------------------------------------
  // State update
  // ---------------------------------------------------------------------------
  // NOTE: all state in this block is assigned with non-blocking (<=) so every
  // register samples the pre-edge values, independent of statement order.
  // The bypass data register is small and is reset with everything else so
  // that no output can ever show stale or X data after reset.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_wr_last  <= SEL_B;
      r_rd_last  <= SEL_B;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_byp      <= 1'b0;
      r_byp_data <= '0;
    end else begin
      // Pointers move only when their port actually grants.
      if (w_wr_gnt_a) begin
        r_wr_last <= SEL_A;
      end else if (w_wr_gnt_b) begin
        r_wr_last <= SEL_B;
      end

      if (w_rd_gnt_a) begin
        r_rd_last <= SEL_A;
      end else if (w_rd_gnt_b) begin
        r_rd_last <= SEL_B;
      end

      // One-cycle read latency: the grant cycle's flag becomes the rvalid pulse.
      r_a_rvalid <= w_rd_gnt_a;
      r_b_rvalid <= w_rd_gnt_b;

      r_byp <= w_byp_hit;
      if (w_byp_hit) begin
        r_byp_data <= o_mem_wdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read return
  // ---------------------------------------------------------------------------
  // At most one read is granted per cycle, so one shared return value serves
  // both requesters; the rvalid flags steer and gate it.
  logic [DW-1:0] w_ret_data;

  assign w_ret_data = r_byp ? r_byp_data : i_mem_rdata;

  assign o_a_rvalid = r_a_rvalid;
  assign o_b_rvalid = r_b_rvalid;
  assign o_a_rdata  = r_a_rvalid ? w_ret_data : '0;
  assign o_b_rdata  = r_b_rvalid ? w_ret_data : '0;

endmodule

// File: tb/tb_dp_mem_arb2.sv
// -----------------------------------------------------------------------------
// tb_dp_mem_arb2
//
// Directed bench for dp_mem_arb2. A behavioural 512x8 RAM (registered read,
// old data on a same-address collision) sits on the memory port. Each step
// drives both requesters after the falling edge, checks grants and memory-side
// outputs combinationally, and pushes the expected read data into a queue;
// the following step pops it and checks the rvalid/rdata pulse.
// -----------------------------------------------------------------------------
module tb_dp_mem_arb2;

  localparam int AW = 9;
  localparam int DW = 8;

  logic          i_clk;
  logic          i_nrst;
  logic          i_a_req, i_a_we;
  logic [AW-1:0] i_a_addr;
  logic [DW-1:0] i_a_wdata;
  logic          o_a_gnt, o_a_rvalid;
  logic [DW-1:0] o_a_rdata;
  logic          i_b_req, i_b_we;
  logic [AW-1:0] i_b_addr;
  logic [DW-1:0] i_b_wdata;
  logic          o_b_gnt, o_b_rvalid;
  logic [DW-1:0] o_b_rdata;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_waddr;
  logic [DW-1:0] o_mem_wdata;
  logic [AW-1:0] o_mem_raddr;
  logic [DW-1:0] i_mem_rdata;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic          who;   // 0 = A, 1 = B
    logic [DW-1:0] data;
  } rd_exp_t;

  rd_exp_t sb[$];

  dp_mem_arb2 #(.AW(AW), .DW(DW)) dut (
    .i_clk       (i_clk),
    .i_nrst      (i_nrst),
    .i_a_req     (i_a_req),
    .i_a_we      (i_a_we),
    .i_a_addr    (i_a_addr),
    .i_a_wdata   (i_a_wdata),
    .o_a_gnt     (o_a_gnt),
    .o_a_rvalid  (o_a_rvalid),
    .o_a_rdata   (o_a_rdata),
    .i_b_req     (i_b_req),
    .i_b_we      (i_b_we),
    .i_b_addr    (i_b_addr),
    .i_b_wdata   (i_b_wdata),
    .o_b_gnt     (o_b_gnt),
    .o_b_rvalid  (o_b_rvalid),
    .o_b_rdata   (o_b_rdata),
    .o_mem_we    (o_mem_we),
    .o_mem_waddr (o_mem_waddr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_raddr (o_mem_raddr),
    .i_mem_rdata (i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Behavioural RAM: write and registered read on the same edge, so a
  // same-address collision returns the old contents.
  logic [DW-1:0] mem [0:511];
  always @(posedge i_clk) begin
    if (o_mem_we) mem[o_mem_waddr] <= o_mem_wdata;
    i_mem_rdata <= mem[o_mem_raddr];
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the read-return outputs against the oldest queued expectation.
  task automatic check_return();
    rd_exp_t e;
    logic    has;
    logic    ea, eb;
    has = (sb.size() > 0);
    e   = '0;
    if (has) e = sb.pop_front();
    ea = has && !e.who;
    eb = has &&  e.who;
    check("a_rvalid", {15'd0, o_a_rvalid}, {15'd0, ea});
    check("a_rdata",  {8'd0, o_a_rdata},   {8'd0, (ea ? e.data : 8'h00)});
    check("b_rvalid", {15'd0, o_b_rvalid}, {15'd0, eb});
    check("b_rdata",  {8'd0, o_b_rdata},   {8'd0, (eb ? e.data : 8'h00)});
  endtask

  task automatic step(
    input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
    input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
    input logic eag, input logic ebg,
    input logic ewe, input logic [AW-1:0] ewa, input logic [DW-1:0] ewd,
    input logic [AW-1:0] era, input logic [DW-1:0] erd
  );
    @(negedge i_clk);
    i_a_req = ar; i_a_we = aw; i_a_addr = aa; i_a_wdata = ad;
    i_b_req = br; i_b_we = bw; i_b_addr = ba; i_b_wdata = bd;
    #1;
    check_return();
    check("a_gnt",     {15'd0, o_a_gnt},     {15'd0, eag});
    check("b_gnt",     {15'd0, o_b_gnt},     {15'd0, ebg});
    check("mem_we",    {15'd0, o_mem_we},    {15'd0, ewe});
    check("mem_waddr", {7'd0, o_mem_waddr},  {7'd0, ewa});
    check("mem_wdata", {8'd0, o_mem_wdata},  {8'd0, ewd});
    check("mem_raddr", {7'd0, o_mem_raddr},  {7'd0, era});
    if (eag && !aw) sb.push_back('{1'b0, erd});
    if (ebg && !bw) sb.push_back('{1'b1, erd});
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, 0, '0, '0, 0, 0, 0, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_a_req = 0; i_a_we = 0; i_a_addr = '0; i_a_wdata = '0;
    i_b_req = 0; i_b_we = 0; i_b_addr = '0; i_b_wdata = '0;
    i_nrst = 1'b0;
    sb.delete();
    @(negedge i_clk);
    i_nrst = 1'b1;
  endtask

  initial begin
    logic win;

    // Reset with no requests: every output is 0.
    i_nrst = 1'b0;
    i_a_req = 0; i_a_we = 0; i_a_addr = '0; i_a_wdata = '0;
    i_b_req = 0; i_b_we = 0; i_b_addr = '0; i_b_wdata = '0;
    #12;
    check_return();
    check("rst_a_gnt",  {15'd0, o_a_gnt},   16'd0);
    check("rst_b_gnt",  {15'd0, o_b_gnt},   16'd0);
    check("rst_mem_we", {15'd0, o_mem_we},  16'd0);
    check("rst_raddr",  {7'd0, o_mem_raddr}, 16'd0);
    @(negedge i_clk);
    i_nrst = 1'b1;
    idle();

    // Lone write then read-back of the same address.
    step(1, 1, 9'h1A5, 8'h3C, 0, 0, '0, '0, 1, 0, 1, 9'h1A5, 8'h3C, '0, '0);
    step(1, 0, 9'h1A5, '0,    0, 0, '0, '0, 1, 0, 0, '0, '0, 9'h1A5, 8'h3C);
    idle();

    // Write contention after reset: A, B, A, B.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      win = (i % 2 == 0);
      step(1, 1, 9'h010, 8'h11, 1, 1, 9'h020, 8'h22, win, !win,
           1, (win ? 9'h010 : 9'h020), (win ? 8'h11 : 8'h22), '0, '0);
    end
    // Read contention: A first again (read pointer untouched by writes).
    for (int i = 0; i < 4; i++) begin
      win = (i % 2 == 0);
      step(1, 0, 9'h010, '0, 1, 0, 9'h020, '0, win, !win,
           0, '0, '0, (win ? 9'h010 : 9'h020), (win ? 8'h11 : 8'h22));
    end
    idle();

    // Same-cycle read (A) and write (B) to 0x0FF: bypass, then from memory.
    step(1, 0, 9'h0FF, '0, 1, 1, 9'h0FF, 8'h5A, 1, 1, 1, 9'h0FF, 8'h5A, 9'h0FF, 8'h5A);
    step(1, 0, 9'h0FF, '0, 0, 0, '0, '0,        1, 0, 0, '0, '0,       9'h0FF, 8'h5A);
    idle();

    // Seed 0x1FF and 0x000, then six contended back-to-back reads.
    // Read pointer is A (last read above), so B wins first.
    step(1, 1, 9'h1FF, 8'h7E, 0, 0, '0, '0, 1, 0, 1, 9'h1FF, 8'h7E, '0, '0);
    step(0, 0, '0, '0, 1, 1, 9'h000, 8'hC3, 0, 1, 1, 9'h000, 8'hC3, '0, '0);
    for (int i = 0; i < 6; i++) begin
      win = (i % 2 == 0);  // 1 = B wins this cycle
      step(1, 0, 9'h000, '0, 1, 0, 9'h1FF, '0, !win, win,
           0, '0, '0, (win ? 9'h1FF : 9'h000), (win ? 8'h7E : 8'hC3));
    end
    idle();

    // Leave both pointers at A, grant a read, then reset during the return.
    step(1, 1, 9'h050, 8'h77, 0, 0, '0, '0, 1, 0, 1, 9'h050, 8'h77, '0, '0);
    step(1, 0, 9'h050, '0,    0, 0, '0, '0, 1, 0, 0, '0, '0, 9'h050, 8'h77);
    idle();  // rvalid for A is high here
    i_nrst = 1'b0;
    #1;
    check("mid_rst_a_rvalid", {15'd0, o_a_rvalid}, 16'd0);
    check("mid_rst_a_rdata",  {8'd0, o_a_rdata},   16'd0);
    check("mid_rst_b_rvalid", {15'd0, o_b_rvalid}, 16'd0);
    sb.delete();
    @(negedge i_clk);
    i_nrst = 1'b1;

    // After release A wins the first contention on both ports.
    step(1, 1, 9'h060, 8'h01, 1, 1, 9'h061, 8'h02, 1, 0, 1, 9'h060, 8'h01, '0, '0);
    step(1, 0, 9'h060, '0,    1, 0, 9'h061, '0,    1, 0, 0, '0, '0, 9'h060, 8'h01);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
